// File: rtl/mux_alusrcb_pipe.sv
`default_nettype none
// ============================================================================
// Module   : mux_alusrcb_pipe
// Purpose  : ALU source-B operand selector feeding a 2-entry skid buffer
//            (valid/ready on both sides, sticky out-of-range select flag).
//            Optional macro MUX_ALUSRCB_BYPASS_EN: zero-latency path when empty.
// Revision : 1.0  initial release
// ============================================================================
module mux_alusrcb_pipe #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 5,
    parameter int SEL_W = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_IN*WIDTH-1:0]   in_bus,
    input  logic [SEL_W-1:0]        sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err,
    input  logic                    err_clr
);

    localparam logic [SEL_W:0] c_n_in = (SEL_W+1)'(N_IN);

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_main;
    logic [WIDTH-1:0]   r_skid;
    logic               r_in_ready;
    logic               r_sel_err;

    logic [WIDTH-1:0]   w_sel_data;
    logic               w_sel_oor;
    logic               w_accept;
    logic               w_consume;
    logic               w_main_ld;
    logic               w_main_from_skid;
    logic               w_skid_ld;

    // Out-of-range selects fall through to the last operand.
    always_comb begin
        w_sel_data = in_bus[(N_IN-1)*WIDTH +: WIDTH];
        for (int k = 0; k < N_IN-1; k++) begin
            if (sel == SEL_W'(k)) begin
                w_sel_data = in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    assign w_sel_oor = ({1'b0, sel} >= c_n_in);
    assign in_ready  = r_in_ready;
    assign sel_err   = r_sel_err;
    assign w_accept  = in_valid && r_in_ready;
    assign w_consume = out_valid && out_ready;

`ifdef MUX_ALUSRCB_BYPASS_EN
    assign out_valid = (r_state == S_EMPTY) ? w_accept : 1'b1;
    assign out_data  = ((r_state == S_EMPTY) && w_accept) ? w_sel_data : r_main;
`else
    assign out_valid = (r_state != S_EMPTY);
    assign out_data  = r_main;
`endif

    always_comb begin
        w_state_nxt      = r_state;
        w_main_ld        = 1'b0;
        w_main_from_skid = 1'b0;
        w_skid_ld        = 1'b0;
        case (r_state)
            S_EMPTY: begin
`ifdef MUX_ALUSRCB_BYPASS_EN
                // A same-cycle consumer takes the operand straight through.
                if (w_accept && !out_ready) begin
                    w_main_ld   = 1'b1;
                    w_state_nxt = S_ONE;
                end
`else
                if (w_accept) begin
                    w_main_ld   = 1'b1;
                    w_state_nxt = S_ONE;
                end
`endif
            end
            S_ONE: begin
                if (w_accept && w_consume) begin
                    w_main_ld   = 1'b1;
                end else if (w_accept) begin
                    w_skid_ld   = 1'b1;
                    w_state_nxt = S_FULL;
                end else if (w_consume) begin
                    w_state_nxt = S_EMPTY;
                end
            end
            S_FULL: begin
                if (w_consume) begin
                    w_main_ld        = 1'b1;
                    w_main_from_skid = 1'b1;
                    w_state_nxt      = S_ONE;
                end
            end
            default: begin
                w_state_nxt = S_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_EMPTY;
            r_main     <= '0;
            r_skid     <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            // Ready is registered from the next state so out_ready never reaches in_ready.
            r_in_ready <= (w_state_nxt != S_FULL);
            if (w_main_ld) begin
                r_main <= w_main_from_skid ? r_skid : w_sel_data;
            end
            if (w_skid_ld) begin
                r_skid <= w_sel_data;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sel_err <= 1'b0;
        end else if (w_accept && w_sel_oor) begin
            r_sel_err <= 1'b1;
        end else if (err_clr) begin
            r_sel_err <= 1'b0;
        end
    end

endmodule
`default_nettype wire
